// File: rtl/mcht_pkg.sv
// Shared types and constants for the BIST controller and its LFSR.
package mcht_pkg;

   localparam int                cMSG_W     = 8;
   localparam logic [cMSG_W-1:0] cLFSR_TAPS = 8'hB8;   // x^8+x^6+x^5+x^4+1
   localparam logic [cMSG_W-1:0] cDEF_SEED  = 8'hA5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SEND    = 3'd2,
      WAIT_RX = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5
   } state_e;

   // One Galois step: shift right, fold the taps back in when a 1 falls out.
   function automatic logic [cMSG_W-1:0] lfsr_next(input logic [cMSG_W-1:0] v);
      return (v >> 1) ^ (v[0] ? cLFSR_TAPS : '0);
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [cMSG_W-1:0] fix_seed(input logic [cMSG_W-1:0] s);
      return (s == '0) ? {{(cMSG_W-1){1'b0}}, 1'b1} : s;
   endfunction

endpackage

// File: rtl/mcht_lfsr.sv
// 8-bit Galois LFSR message generator: load seed, step once per checked message.
module mcht_lfsr
   import mcht_pkg::*;
#(
   parameter logic [cMSG_W-1:0] pSEED = cDEF_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   output logic [cMSG_W-1:0] value
);

   localparam logic [cMSG_W-1:0] cSEED = fix_seed(pSEED);

   logic [cMSG_W-1:0] value_q, value_d;

   // Load wins over step; otherwise hold.
   always_comb begin
      value_d = value_q;
      if (load)      value_d = cSEED;
      else if (step) value_d = lfsr_next(value_q);
   end

   // State register, reset to the seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value_q <= cSEED;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/mcht_bist_ctrl.sv
// Loopback BIST controller: sends LFSR messages to a transceiver, compares the
// echoed message, counts errors and reports PASS/FAIL.
// Optional build macro MCHT_BIST_TMO_EN adds a receive-wait timeout of pTMO
// cycles; without it WAIT_RX waits for a capture, HALT or reset.
module mcht_bist_ctrl
   import mcht_pkg::*;
#(
   parameter logic [cMSG_W-1:0] pSEED = cDEF_SEED,
   parameter int                pTMO  = 1023
) (
   input  logic              CLK_25M,
   input  logic              RST_N,
   input  logic              START,
   input  logic              HALT,
   input  logic [cMSG_W-1:0] NUM_MSG,
   output logic              TX_VLD,
   output logic [cMSG_W-1:0] TX_MSG,
   input  logic              TX_DNE,
   input  logic [cMSG_W-1:0] RX_MSG,
   input  logic              RX_VLD,
   output logic              BUSY,
   output logic              PASS,
   output logic              FAIL,
   output logic [cMSG_W-1:0] ERR_CNT,
   output logic [cMSG_W-1:0] MSG_CNT
);

   state_e            state_q, state_d;
   logic              tx_vld_q, tx_vld_d;
   logic [cMSG_W-1:0] tx_msg_q, tx_msg_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [cMSG_W-1:0] err_cnt_q, err_cnt_d;
   logic [cMSG_W-1:0] msg_cnt_q, msg_cnt_d;
   logic [cMSG_W-1:0] num_q, num_d;
   logic [cMSG_W-1:0] cap_q, cap_d;
   logic              cap_flg_q, cap_flg_d;
   logic              lfsr_load, lfsr_step;
   logic [cMSG_W-1:0] lfsr_val;
   logic              msg_bad;
   logic              busy;

`ifdef MCHT_BIST_TMO_EN
   localparam int                cTMO_W   = (pTMO > 1) ? $clog2(pTMO + 1) : 1;
   localparam logic [cTMO_W-1:0] cTMO_LIM = pTMO[cTMO_W-1:0];

   logic [cTMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic              tmo_hit_q, tmo_hit_d;
`else
   // The timeout length only matters in the timeout build.
   if (pTMO < 1) begin : g_tmo_unused
   end
`endif

   mcht_lfsr #(.pSEED(pSEED)) u_lfsr (
      .clk   (CLK_25M),
      .rst_n (RST_N),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .value (lfsr_val)
   );

   assign busy = (state_q == LOAD) || (state_q == SEND) ||
                 (state_q == WAIT_RX) || (state_q == CHECK);

   // Next-state, counters and handshake; HALT is applied last so it overrides everything.
   always_comb begin
      state_d   = state_q;
      tx_vld_d  = tx_vld_q;
      tx_msg_d  = tx_msg_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_cnt_d = err_cnt_q;
      msg_cnt_d = msg_cnt_q;
      num_d     = num_q;
      cap_d     = cap_q;
      cap_flg_d = cap_flg_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      msg_bad   = (cap_q != tx_msg_q);
`ifdef MCHT_BIST_TMO_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_hit_d = tmo_hit_q;
      msg_bad   = msg_bad | tmo_hit_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (START && !HALT) begin
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               err_cnt_d = '0;
               msg_cnt_d = '0;
               num_d     = NUM_MSG;
               cap_flg_d = 1'b0;
               lfsr_load = 1'b1;
               if (NUM_MSG == '0) begin
                  state_d = DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            tx_msg_d = lfsr_val;
            tx_vld_d = 1'b1;
            state_d  = SEND;
         end
         SEND: begin
            if (TX_DNE) begin
               tx_vld_d = 1'b0;
               state_d  = WAIT_RX;
`ifdef MCHT_BIST_TMO_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         WAIT_RX: begin
            if (cap_flg_q) begin
               state_d = CHECK;
            end
`ifdef MCHT_BIST_TMO_EN
            else if (!RX_VLD && (tmo_cnt_q == cTMO_LIM)) begin
               tmo_hit_d = 1'b1;
               state_d   = CHECK;
            end else if (tmo_cnt_q != cTMO_LIM) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         CHECK: begin
            if (msg_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
            msg_cnt_d = msg_cnt_q + 1'b1;
            lfsr_step = 1'b1;
            cap_flg_d = 1'b0;
`ifdef MCHT_BIST_TMO_EN
            tmo_hit_d = 1'b0;
`endif
            if (msg_cnt_d == num_q) begin
               state_d = DONE;
               pass_d  = (err_cnt_d == '0);
               fail_d  = (err_cnt_d != '0);
            end else begin
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase

      // Echo capture is only meaningful while a message is in flight.
      if (RX_VLD && ((state_q == SEND) || (state_q == WAIT_RX))) begin
         cap_d     = RX_MSG;
         cap_flg_d = 1'b1;
      end

      // Abort: back to IDLE, counters kept, no verdict.
      if (HALT && busy) begin
         state_d   = IDLE;
         tx_vld_d  = 1'b0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         err_cnt_d = err_cnt_q;
         msg_cnt_d = msg_cnt_q;
         cap_d     = cap_q;
         cap_flg_d = 1'b0;
         lfsr_load = 1'b0;
         lfsr_step = 1'b0;
`ifdef MCHT_BIST_TMO_EN
         tmo_hit_d = 1'b0;
`endif
      end
   end

   // Controller state registers.
   always_ff @(posedge CLK_25M or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         tx_vld_q  <= 1'b0;
         tx_msg_q  <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         err_cnt_q <= '0;
         msg_cnt_q <= '0;
         num_q     <= '0;
         cap_q     <= '0;
         cap_flg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_vld_q  <= tx_vld_d;
         tx_msg_q  <= tx_msg_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_cnt_q <= err_cnt_d;
         msg_cnt_q <= msg_cnt_d;
         num_q     <= num_d;
         cap_q     <= cap_d;
         cap_flg_q <= cap_flg_d;
      end
   end

`ifdef MCHT_BIST_TMO_EN
   // Receive-wait timeout counter and its pending-error marker.
   always_ff @(posedge CLK_25M or negedge RST_N) begin
      if (!RST_N) begin
         tmo_cnt_q <= '0;
         tmo_hit_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_hit_q <= tmo_hit_d;
      end
   end
`endif

   assign TX_VLD  = tx_vld_q;
   assign TX_MSG  = tx_msg_q;
   assign BUSY    = busy;
   assign PASS    = pass_q;
   assign FAIL    = fail_q;
   assign ERR_CNT = err_cnt_q;
   assign MSG_CNT = msg_cnt_q;

endmodule

// File: tb/tb_mcht_bist_ctrl.sv
// Bench for mcht_bist_ctrl: acts as the transceiver (TX_DNE, loopback RX),
// scoreboards the TX message sequence and checks run verdicts.
module tb_mcht_bist_ctrl;

   logic       CLK_25M = 1'b0;
   logic       RST_N   = 1'b0;
   logic       START   = 1'b0;
   logic       HALT    = 1'b0;
   logic [7:0] NUM_MSG = '0;
   logic       TX_VLD;
   logic [7:0] TX_MSG;
   logic       TX_DNE  = 1'b0;
   logic [7:0] RX_MSG  = '0;
   logic       RX_VLD  = 1'b0;
   logic       BUSY, PASS, FAIL;
   logic [7:0] ERR_CNT, MSG_CNT;

   int         vec_cnt  = 0;
   int         miss_cnt = 0;
   logic [7:0] exp_q[$];
   // Sequence from seed A5 under x^8+x^6+x^5+x^4+1 (Galois, right shift).
   logic [7:0] seq_tbl [4] = '{8'hA5, 8'hEA, 8'h75, 8'h82};

   mcht_bist_ctrl #(.pSEED(8'hA5), .pTMO(16)) dut (
      .CLK_25M (CLK_25M), .RST_N (RST_N), .START (START), .HALT (HALT),
      .NUM_MSG (NUM_MSG), .TX_VLD (TX_VLD), .TX_MSG (TX_MSG), .TX_DNE (TX_DNE),
      .RX_MSG (RX_MSG), .RX_VLD (RX_VLD), .BUSY (BUSY), .PASS (PASS),
      .FAIL (FAIL), .ERR_CNT (ERR_CNT), .MSG_CNT (MSG_CNT)
   );

   always #20 CLK_25M = ~CLK_25M;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLK_25M);
      #1;
   endtask

   task automatic start_run(input int n);
      for (int i = 0; i < n && i < 4; i++) exp_q.push_back(seq_tbl[i]);
      NUM_MSG = 8'(n);
      START   = 1'b1;
      tick();
      START   = 1'b0;
   endtask

   task automatic wait_tx(input int bound, output bit ok);
      int k = 0;
      logic [7:0] e;
      while (TX_VLD !== 1'b1 && k < bound) begin tick(); k++; end
      vec_cnt++;
      if (TX_VLD !== 1'b1) begin
         miss_cnt++;
         $display("FAIL tx_vld_wait: TX_VLD=%b after %0d cycles, want 1", TX_VLD, k);
         ok = 1'b0;
         return;
      end
      ok = 1'b1;
      if (exp_q.size() == 0) e = 'x;
      else                   e = exp_q.pop_front();
      vec_cnt++;
      if (TX_MSG !== e) begin
         miss_cnt++;
         $display("FAIL tx_msg: got %h want %h", TX_MSG, e);
      end
   endtask

   // One message handshake as seen by the transceiver.
   task automatic xfer(input int i, input int flip_idx, input bit early, input bit no_rx);
      bit ok;
      logic [7:0] m;
      wait_tx(80, ok);
      if (!ok) return;
      m = TX_MSG;
      if (i == flip_idx) m = m ^ 8'h01;
      if (early) begin
         RX_MSG = m; RX_VLD = 1'b1; tick(); RX_VLD = 1'b0;
      end
      tick();
      TX_DNE = 1'b1; tick(); TX_DNE = 1'b0;
      vec_cnt++;
      if (TX_VLD !== 1'b0) begin
         miss_cnt++;
         $display("FAIL tx_vld_drop: got %b want 0", TX_VLD);
      end
      if (early) begin
         tick(); tick();
         vec_cnt++;
         if (MSG_CNT !== 8'(i + 1)) begin
            miss_cnt++;
            $display("FAIL early_check_cnt: got %0d want %0d", MSG_CNT, i + 1);
         end
      end else if (!no_rx) begin
         repeat (39) tick();
         RX_MSG = m; RX_VLD = 1'b1; tick(); RX_VLD = 1'b0;
      end
   endtask

   task automatic wait_idle;
      int k = 0;
      while (BUSY === 1'b1 && k < 80) begin tick(); k++; end
      vec_cnt++;
      if (BUSY !== 1'b0) begin
         miss_cnt++;
         $display("FAIL run_end: BUSY=%b want 0", BUSY);
      end
   endtask

   task automatic run(input int n, input int flip_idx, input bit early, input bit no_rx);
      start_run(n);
      vec_cnt++;
      if ({TX_VLD, PASS, FAIL, ERR_CNT, MSG_CNT} !== 19'd0 || BUSY !== 1'b1) begin
         miss_cnt++;
         $display("FAIL start_clear: vld=%b pass=%b fail=%b err=%0d cnt=%0d busy=%b want 0,0,0,0,0,1",
                  TX_VLD, PASS, FAIL, ERR_CNT, MSG_CNT, BUSY);
      end
      tick();
      vec_cnt++;
      if (TX_VLD !== 1'b1) begin
         miss_cnt++;
         $display("FAIL tx_vld_latency: got %b want 1 two cycles after START", TX_VLD);
      end
      for (int i = 0; i < n; i++) xfer(i, flip_idx, early, no_rx);
      wait_idle();
   endtask

   task automatic check_verdict(input string name, input logic [7:0] cnt, input logic [7:0] err,
                                input logic p, input logic f);
      vec_cnt++;
      if (MSG_CNT !== cnt || ERR_CNT !== err || PASS !== p || FAIL !== f) begin
         miss_cnt++;
         $display("FAIL %s: cnt=%0d err=%0d pass=%b fail=%b want cnt=%0d err=%0d pass=%b fail=%b",
                  name, MSG_CNT, ERR_CNT, PASS, FAIL, cnt, err, p, f);
      end
   endtask

   task automatic test_reset;
      vec_cnt++;
      if ({TX_VLD, TX_MSG, BUSY, PASS, FAIL, ERR_CNT, MSG_CNT} !== 28'd0) begin
         miss_cnt++;
         $display("FAIL reset: vld=%b msg=%h busy=%b pass=%b fail=%b err=%0d cnt=%0d want all 0",
                  TX_VLD, TX_MSG, BUSY, PASS, FAIL, ERR_CNT, MSG_CNT);
      end
   endtask

   task automatic test_loopback;
      run(4, -1, 1'b0, 1'b0);
      check_verdict("loopback", 8'd4, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic test_mismatch;
      run(4, 1, 1'b0, 1'b0);
      check_verdict("mismatch", 8'd4, 8'd1, 1'b0, 1'b1);
   endtask

   task automatic test_zero_msg;
      bit seen = 1'b0;
      NUM_MSG = 8'd0; START = 1'b1; tick(); START = 1'b0;
      vec_cnt++;
      if (PASS !== 1'b1 || FAIL !== 1'b0 || BUSY !== 1'b0) begin
         miss_cnt++;
         $display("FAIL zero_msg: pass=%b fail=%b busy=%b want 1,0,0", PASS, FAIL, BUSY);
      end
      repeat (6) begin if (TX_VLD !== 1'b0) seen = 1'b1; tick(); end
      vec_cnt++;
      if (seen || MSG_CNT !== 8'd0) begin
         miss_cnt++;
         $display("FAIL zero_msg_tx: tx_seen=%b cnt=%0d want 0,0", seen, MSG_CNT);
      end
   endtask

   task automatic test_halt;
      bit ok;
      bit seen = 1'b0;
      start_run(3);
      xfer(0, -1, 1'b0, 1'b0);
      wait_tx(80, ok);
      // START while busy must not restart or finish the run.
      NUM_MSG = 8'd0; START = 1'b1; tick(); START = 1'b0;
      vec_cnt++;
      if (BUSY !== 1'b1 || PASS !== 1'b0 || TX_VLD !== 1'b1 || MSG_CNT !== 8'd1) begin
         miss_cnt++;
         $display("FAIL start_busy: busy=%b pass=%b vld=%b cnt=%0d want 1,0,1,1", BUSY, PASS, TX_VLD, MSG_CNT);
      end
      TX_DNE = 1'b1; tick(); TX_DNE = 1'b0;
      tick();
      HALT = 1'b1; tick(); HALT = 1'b0;
      vec_cnt++;
      if (BUSY !== 1'b0 || TX_VLD !== 1'b0 || PASS !== 1'b0 || FAIL !== 1'b0 || MSG_CNT !== 8'd1) begin
         miss_cnt++;
         $display("FAIL halt: busy=%b vld=%b pass=%b fail=%b cnt=%0d want 0,0,0,0,1",
                  BUSY, TX_VLD, PASS, FAIL, MSG_CNT);
      end
      // A late echo after the abort is ignored.
      RX_MSG = 8'hEA; RX_VLD = 1'b1; tick(); RX_VLD = 1'b0;
      repeat (10) begin if (TX_VLD !== 1'b0 || BUSY !== 1'b0) seen = 1'b1; tick(); end
      vec_cnt++;
      if (seen) begin
         miss_cnt++;
         $display("FAIL halt_idle: activity after HALT=%b want 0", seen);
      end
      exp_q.delete();
   endtask

   task automatic test_early_rx;
      run(2, -1, 1'b1, 1'b0);
      check_verdict("early_rx", 8'd2, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic test_timeout;
`ifdef MCHT_BIST_TMO_EN
      run(2, -1, 1'b0, 1'b1);
      check_verdict("timeout", 8'd2, 8'd2, 1'b0, 1'b1);
`else
      start_run(2);
      tick();
      xfer(0, -1, 1'b0, 1'b1);
      repeat (200) tick();
      vec_cnt++;
      if (BUSY !== 1'b1 || MSG_CNT !== 8'd0 || ERR_CNT !== 8'd0) begin
         miss_cnt++;
         $display("FAIL no_timeout: busy=%b cnt=%0d err=%0d want 1,0,0", BUSY, MSG_CNT, ERR_CNT);
      end
      HALT = 1'b1; tick(); HALT = 1'b0;
      vec_cnt++;
      if (BUSY !== 1'b0) begin
         miss_cnt++;
         $display("FAIL no_timeout_halt: busy=%b want 0", BUSY);
      end
      exp_q.delete();
`endif
   endtask

   task automatic test_reset_midrun;
      bit ok;
      bit seen = 1'b0;
      start_run(4);
      wait_tx(80, ok);
      RST_N = 1'b0;
      #1;
      vec_cnt++;
      if (TX_VLD !== 1'b0 || BUSY !== 1'b0 || TX_MSG !== 8'h00) begin
         miss_cnt++;
         $display("FAIL reset_midrun: vld=%b busy=%b msg=%h want 0,0,00", TX_VLD, BUSY, TX_MSG);
      end
      tick(); tick();
      RST_N = 1'b1;
      exp_q.delete();
      repeat (50) begin if (TX_VLD !== 1'b0) seen = 1'b1; tick(); end
      vec_cnt++;
      if (seen) begin
         miss_cnt++;
         $display("FAIL reset_quiet: TX_VLD seen=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      run(3, 2, 1'b0, 1'b0);
      check_verdict("b2b_first", 8'd3, 8'd1, 1'b0, 1'b1);
      run(1, -1, 1'b0, 1'b0);
      check_verdict("b2b_second", 8'd1, 8'd0, 1'b1, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      test_reset();
      RST_N = 1'b1;
      tick();
      test_loopback();
      test_mismatch();
      test_zero_msg();
      test_halt();
      test_early_rx();
      test_timeout();
      test_reset_midrun();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/mcht_bist_ctrl.md
MCHT_BIST_CTRL -- requirements
Module: mcht_bist_ctrl

Interface
REQ-001 SHALL have parameter pSEED, default 8'hA5: LFSR seed loaded on START; 8'h00 is replaced by 8'h01.
REQ-002 SHALL have parameter pTMO, default 1023: receive-wait timeout in CLK_25M cycles; used only under MCHT_BIST_TMO_EN.
REQ-003 SHALL have port CLK_25M, input, 1: single core clock; all logic is rising-edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port START, input, 1: single-cycle run request.
REQ-006 SHALL have port HALT, input, 1: synchronous abort request.
REQ-007 SHALL have port NUM_MSG, input, 8: number of messages per run; sampled on accepted START.
REQ-008 SHALL have port TX_VLD, output, 1: message valid to the transceiver.
REQ-009 SHALL have port TX_MSG, output, 8: message to the transceiver.
REQ-010 SHALL have port TX_DNE, input, 1: transmit-complete pulse from the transceiver.
REQ-011 SHALL have port RX_MSG, input, 8: decoded message from the transceiver.
REQ-012 SHALL have port RX_VLD, input, 1: single-cycle pulse; RX_MSG is valid in the same cycle.
REQ-013 SHALL have port BUSY, output, 1: run in progress.
REQ-014 SHALL have port PASS, output, 1: run completed with ERR_CNT equal to 0.
REQ-015 SHALL have port FAIL, output, 1: run completed with ERR_CNT not equal to 0.
REQ-016 SHALL have port ERR_CNT, output, 8: count of mismatched or timed-out messages; saturates at 255.
REQ-017 SHALL have port MSG_CNT, output, 8: count of messages checked in the current run.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_RX, CHECK, DONE.
REQ-019 IDLE/DONE + START: SHALL clear PASS, FAIL, ERR_CNT and MSG_CNT, load the LFSR with pSEED, latch NUM_MSG, then go to LOAD; if NUM_MSG is 0, SHALL go directly to DONE with PASS set.
REQ-020 LOAD: SHALL drive TX_MSG from the LFSR, then go to SEND; TX_VLD SHALL rise 2 cycles after START.
REQ-021 SEND: TX_VLD SHALL be 1 and TX_MSG SHALL be stable; on TX_DNE, TX_VLD SHALL drop the next cycle and the FSM SHALL go to WAIT_RX.
REQ-022 RX_VLD in SEND or WAIT_RX SHALL capture RX_MSG into a capture register and set a captured flag; RX_VLD in any other state SHALL be ignored.
REQ-023 WAIT_RX: when the captured flag is set, SHALL go to CHECK; this includes the case where the flag was set during SEND.
REQ-024 CHECK: SHALL compare the capture with the sent message; on mismatch ERR_CNT SHALL increment (saturating); MSG_CNT SHALL increment; the LFSR SHALL step once (x^8+x^6+x^5+x^4+1, Galois); the captured flag SHALL clear.
REQ-025 After CHECK: if MSG_CNT equals the latched NUM_MSG, SHALL go to DONE; otherwise SHALL go to LOAD.
REQ-026 DONE: PASS SHALL equal (ERR_CNT==0), FAIL SHALL equal its complement, and both SHALL be held until START or reset.
REQ-027 BUSY SHALL be 1 in LOAD, SEND, WAIT_RX and CHECK.
REQ-028 START while BUSY SHALL be ignored.
REQ-029 HALT SHALL take priority over START and TX_DNE; in any busy state it SHALL return the FSM to IDLE next cycle with TX_VLD=0, counters retained, and PASS/FAIL left at 0.
REQ-030 TX_DNE outside SEND SHALL be ignored.

Reset
REQ-031 On RST_N low, SHALL set FSM=IDLE, TX_VLD=0, TX_MSG=0, BUSY=0, PASS=0, FAIL=0, ERR_CNT=0, MSG_CNT=0, captured flag=0, LFSR=pSEED.
REQ-032 Reset asserted mid-run SHALL abort immediately; no TX_VLD SHALL be issued until a new START.

Configuration
REQ-033 With MCHT_BIST_TMO_EN defined, WAIT_RX SHALL count cycles; when the count reaches pTMO with no capture, SHALL count an error and go to CHECK-equivalent bookkeeping (MSG_CNT++, LFSR step). The counter SHALL clear on entry to WAIT_RX.
REQ-034 Without MCHT_BIST_TMO_EN, WAIT_RX SHALL wait indefinitely (exit only by capture, HALT or reset), and no timeout counter SHALL exist.

Structure
REQ-035 Package mcht_pkg SHALL hold: the FSM state enum, cMSG_W=8, the LFSR tap constant 8'hB8, and the default seed.
REQ-036 The LFSR SHALL be a sub-module mcht_lfsr (load, step, value); the FSM and counters SHALL reside in mcht_bist_ctrl.

Verification
REQ-037 Loopback model echoing TX_MSG as RX_VLD 40 cycles after TX_DNE; NUM_MSG=4 -> TX_MSG sequence A5,... per LFSR; MSG_CNT=4, ERR_CNT=0, PASS=1, FAIL=0.
REQ-038 Same run with RX bit0 flipped on message 2 -> ERR_CNT=1, FAIL=1, PASS=0.
REQ-039 NUM_MSG=0 + START -> no TX_VLD, PASS=1 within 2 cycles.
REQ-040 HALT asserted in WAIT_RX -> IDLE next cycle, BUSY=0, TX_VLD=0, PASS=FAIL=0; START while BUSY has no effect.
REQ-041 MCHT_BIST_TMO_EN with pTMO=16 and no RX_VLD, NUM_MSG=2 -> ERR_CNT=2, FAIL=1; without the macro -> BUSY stays 1.
REQ-042 RX_VLD arriving during SEND (before TX_DNE) -> captured; CHECK follows WAIT_RX within 1 cycle; message is counted and compared correctly.
